// File: rtl/vending_change_dispenser_if.sv
// Request/coin handshake bundle between the vending core, the change
// dispenser and the coin ejector.
interface vending_change_dispenser_if #(
    parameter int AMT_W = 11
);
    // valid/ready: a transfer happens on a rising clk edge where both are high;
    // the sender holds its payload stable while valid is high and ready is low.
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             coin_valid;
    logic [2:0]       coin_code;
    logic             coin_ready;
    logic             done;
    logic [AMT_W-1:0] shortfall;

    modport master (
        output req_valid, req_amount, coin_ready,
        input  req_ready, coin_valid, coin_code, done, shortfall
    );

    modport slave (
        input  req_valid, req_amount, coin_ready,
        output req_ready, coin_valid, coin_code, done, shortfall
    );
endinterface

// File: rtl/vending_change_dispenser.sv
// Greedy change dispenser: emits the largest coin that fits the remaining
// amount and is in stock, one coin per handshake; reports any unpaid rest.
module vending_change_dispenser #(
    parameter int AMT_W      = 11,
    parameter int CNT_W      = 8,
    parameter int INIT_COUNT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    vending_change_dispenser_if.slave bus,
    input  logic                     refill_valid,
    input  logic [2:0]               refill_code,
    input  logic [CNT_W-1:0]         refill_qty,
    input  logic [2:0]               inv_sel,
    output logic [CNT_W-1:0]         inv_count,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {IDLE, SELECT, EMIT, DONE} state_t;

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] shortfall_q;
    logic [2:0]       coin_code_q;
    logic [CNT_W-1:0] count_q    [1:6];
    logic [CNT_W-1:0] count_d    [1:6];
    logic [CNT_W:0]   count_sum  [1:6];
    logic             sel_found;
    logic [2:0]       sel_code;
    logic             coin_xfer;

    function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] code);
        case (code)
            3'd1:    coin_value = AMT_W'(1);
            3'd2:    coin_value = AMT_W'(2);
            3'd3:    coin_value = AMT_W'(5);
            3'd4:    coin_value = AMT_W'(10);
            3'd5:    coin_value = AMT_W'(20);
            3'd6:    coin_value = AMT_W'(50);
            default: coin_value = '0;
        endcase
    endfunction

    assign coin_xfer      = (state_q == EMIT) && bus.coin_ready;
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.coin_valid = (state_q == EMIT);
    assign bus.done       = (state_q == DONE);
    assign bus.coin_code  = coin_code_q;
    assign bus.shortfall  = shortfall_q;
    assign state_dbg      = state_q;

    // Ascending scan: the last qualifying denomination wins, i.e. the largest.
    always_comb begin
        sel_found = 1'b0;
        sel_code  = 3'd0;
        for (int d = 1; d <= 6; d++) begin
            if (coin_value(3'(d)) <= remaining_q && count_q[d] != '0) begin
                sel_found = 1'b1;
                sel_code  = 3'(d);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = (bus.req_amount == '0) ? DONE : SELECT;
            SELECT:  state_d = sel_found ? EMIT : DONE;
            EMIT:    if (bus.coin_ready)
                         state_d = (remaining_q == coin_value(coin_code_q)) ? DONE : SELECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining_q <= '0;
            shortfall_q <= '0;
            coin_code_q <= 3'd0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    remaining_q <= bus.req_amount;
                    shortfall_q <= '0;
                end
                SELECT: if (sel_found) begin
                    coin_code_q <= sel_code;
                end else begin
                    shortfall_q <= remaining_q;
                    remaining_q <= '0;
                end
                EMIT: if (bus.coin_ready) remaining_q <= remaining_q - coin_value(coin_code_q);
                default: ;
            endcase
        end
    end

    // A denomination is only emitted while its count is nonzero, so the
    // decrement never wraps; the sum is one bit wider to catch saturation.
    always_comb begin
        for (int c = 1; c <= 6; c++) begin
            count_sum[c] = {1'b0, count_q[c]};
            if (refill_valid && refill_code == 3'(c)) count_sum[c] = count_sum[c] + {1'b0, refill_qty};
            if (coin_xfer && coin_code_q == 3'(c))    count_sum[c] = count_sum[c] - 1'b1;
            count_d[c] = (count_sum[c] > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : count_sum[c][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 1; c <= 6; c++) count_q[c] <= CNT_W'(INIT_COUNT);
        end else begin
            for (int c = 1; c <= 6; c++) count_q[c] <= count_d[c];
        end
    end

    always_comb begin
        inv_count = '0;
        case (inv_sel)
            3'd1:    inv_count = count_q[1];
            3'd2:    inv_count = count_q[2];
            3'd3:    inv_count = count_q[3];
            3'd4:    inv_count = count_q[4];
            3'd5:    inv_count = count_q[5];
            3'd6:    inv_count = count_q[6];
            default: inv_count = '0;
        endcase
    end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Directed bench for the change dispenser: greedy order, depletion, stalls,
// shortfall, refill saturation and reset abort.
module tb_vending_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refill_valid = 1'b0;
    logic [2:0] refill_code  = 3'd0;
    logic [7:0] refill_qty   = 8'd0;
    logic [2:0] inv_sel      = 3'd0;
    logic [7:0] inv_count;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [2:0]  got_q[$];
    logic [2:0]  exp_q[$];
    logic [10:0] got_shortfall;
    int          got_done_cyc;
    int          got_first_cyc;
    bit          got_timeout;

    vending_change_dispenser_if #(.AMT_W(11)) bus ();

    vending_change_dispenser #(.AMT_W(11), .CNT_W(8), .INIT_COUNT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .refill_valid (refill_valid),
        .refill_code  (refill_code),
        .refill_qty   (refill_qty),
        .inv_sel      (inv_sel),
        .inv_count    (inv_count),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        bus.coin_ready = 1'b1;
        refill_valid   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_refill(input logic [2:0] code, input logic [7:0] qty);
        @(negedge clk);
        refill_valid = 1'b1;
        refill_code  = code;
        refill_qty   = qty;
        @(negedge clk);
        refill_valid = 1'b0;
    endtask

    // Issues one request from IDLE and records the coins handed over, the
    // cycle of the first coin_valid and of done (cycle 1 = right after accept).
    task automatic run_request(input logic [10:0] amount);
        got_q.delete();
        got_timeout   = 1'b0;
        got_done_cyc  = 0;
        got_first_cyc = 0;
        got_shortfall = '0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_amount = amount;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (bus.coin_valid && got_first_cyc == 0) got_first_cyc = cyc;
            if (bus.coin_valid && bus.coin_ready) got_q.push_back(bus.coin_code);
            if (bus.done) begin
                got_done_cyc  = cyc;
                got_shortfall = bus.shortfall;
                break;
            end
            @(negedge clk);
        end
        if (got_done_cyc == 0) got_timeout = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.coin_valid !== 1'b0) begin bad++; $display("FAIL reset_coin_valid got=%b exp=0", bus.coin_valid); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.shortfall !== 11'd0) begin bad++; $display("FAIL reset_shortfall got=%0d exp=0", bus.shortfall); end
        total++; if (bus.coin_code !== 3'd0) begin bad++; $display("FAIL reset_coin_code got=%0d exp=0", bus.coin_code); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        for (int c = 0; c <= 7; c++) begin
            inv_sel = 3'(c);
            #1;
            total++;
            if (inv_count !== ((c >= 1 && c <= 6) ? 8'd8 : 8'd0)) begin
                bad++; $display("FAIL reset_inv code=%0d got=%0d exp=%0d", c, inv_count, (c >= 1 && c <= 6) ? 8 : 0);
            end
        end
    endtask

    task automatic test_greedy_87();
        exp_q = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
        run_request(11'd87);
        total++; if (got_timeout) begin bad++; $display("FAIL greedy87_timeout got=no_done exp=done"); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL greedy87_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL greedy87_coin idx=%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 3'd0, exp_q[i]);
            end
        end
        total++; if (got_shortfall !== 11'd0) begin bad++; $display("FAIL greedy87_shortfall got=%0d exp=0", got_shortfall); end
        total++; if (got_first_cyc != 2) begin bad++; $display("FAIL greedy87_first_valid got=%0d exp=2", got_first_cyc); end
        total++; if (got_done_cyc != 11) begin bad++; $display("FAIL greedy87_done_cyc got=%0d exp=11", got_done_cyc); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL greedy87_done_pulse got=%b exp=0", bus.done); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL greedy87_ready_back got=%b exp=1", bus.req_ready); end
        for (int c = 1; c <= 6; c++) begin
            inv_sel = 3'(c);
            #1;
            total++;
            if (inv_count !== ((c == 1) ? 8'd8 : 8'd7)) begin
                bad++; $display("FAIL greedy87_inv code=%0d got=%0d exp=%0d", c, inv_count, (c == 1) ? 8 : 7);
            end
        end
    endtask

    task automatic test_depleted_50();
        apply_reset();
        run_request(11'd400);
        total++; if (got_timeout || got_q.size() != 8) begin bad++; $display("FAIL deplete400_count got=%0d exp=8", got_q.size()); end
        total++; if (got_done_cyc != 17) begin bad++; $display("FAIL deplete400_done_cyc got=%0d exp=17", got_done_cyc); end
        inv_sel = 3'd6; #1;
        total++; if (inv_count !== 8'd0) begin bad++; $display("FAIL deplete400_inv6 got=%0d exp=0", inv_count); end
        run_request(11'd100);
        total++; if (got_timeout || got_q.size() != 5) begin bad++; $display("FAIL deplete100_count got=%0d exp=5", got_q.size()); end
        foreach (got_q[i]) begin
            total++; if (got_q[i] !== 3'd5) begin bad++; $display("FAIL deplete100_coin idx=%0d got=%0d exp=5", i, got_q[i]); end
        end
        total++; if (got_shortfall !== 11'd0) begin bad++; $display("FAIL deplete100_shortfall got=%0d exp=0", got_shortfall); end
        inv_sel = 3'd5; #1;
        total++; if (inv_count !== 8'd3) begin bad++; $display("FAIL deplete100_inv5 got=%0d exp=3", inv_count); end
    endtask

    // Follows depletion: no 50gr coins, three 20gr coins left.
    task automatic test_stall();
        @(negedge clk);
        bus.coin_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_amount = 11'd20;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        inv_sel = 3'd5;
        for (int cyc = 2; cyc <= 5; cyc++) begin
            @(negedge clk);
            #1;
            total++;
            if (bus.coin_valid !== 1'b1 || bus.coin_code !== 3'd5 || inv_count !== 8'd3) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=v%b c%0d n%0d exp=v1 c5 n3", cyc, bus.coin_valid, bus.coin_code, inv_count);
            end
            if (cyc == 5) bus.coin_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        total++; if (bus.done !== 1'b1 || bus.coin_valid !== 1'b0) begin bad++; $display("FAIL stall_done got=d%b v%b exp=d1 v0", bus.done, bus.coin_valid); end
        total++; if (inv_count !== 8'd2) begin bad++; $display("FAIL stall_single_dec got=%0d exp=2", inv_count); end
    endtask

    task automatic test_shortfall();
        apply_reset();
        for (int i = 0; i < 8; i++) run_request(11'd1);
        run_request(11'd694);
        total++; if (got_timeout || got_q.size() != 39) begin bad++; $display("FAIL drain694_count got=%0d exp=39", got_q.size()); end
        for (int c = 1; c <= 6; c++) begin
            inv_sel = 3'(c); #1;
            total++;
            if (inv_count !== ((c == 2) ? 8'd1 : 8'd0)) begin
                bad++; $display("FAIL drain_inv code=%0d got=%0d exp=%0d", c, inv_count, (c == 2) ? 1 : 0);
            end
        end
        run_request(11'd5);
        total++; if (got_q.size() != 1 || got_q[0] !== 3'd2) begin bad++; $display("FAIL short5_coin got=n%0d exp=one coin 2", got_q.size()); end
        total++; if (got_shortfall !== 11'd3) begin bad++; $display("FAIL short5_shortfall got=%0d exp=3", got_shortfall); end
        total++; if (got_done_cyc != 4) begin bad++; $display("FAIL short5_done_cyc got=%0d exp=4", got_done_cyc); end
        @(negedge clk);
        total++; if (bus.shortfall !== 11'd3) begin bad++; $display("FAIL short5_held got=%0d exp=3", bus.shortfall); end
        run_request(11'd0);
        total++; if (got_done_cyc != 1) begin bad++; $display("FAIL zero_done_cyc got=%0d exp=1", got_done_cyc); end
        total++; if (got_shortfall !== 11'd0) begin bad++; $display("FAIL zero_shortfall got=%0d exp=0", got_shortfall); end
        total++; if (got_first_cyc != 0) begin bad++; $display("FAIL zero_no_coin got=%0d exp=0", got_first_cyc); end
    endtask

    task automatic test_refill();
        apply_reset();
        inv_sel = 3'd4;
        do_refill(3'd4, 8'd242);
        total++; if (inv_count !== 8'd250) begin bad++; $display("FAIL refill_add got=%0d exp=250", inv_count); end
        do_refill(3'd4, 8'd255);
        total++; if (inv_count !== 8'd255) begin bad++; $display("FAIL refill_saturate got=%0d exp=255", inv_count); end
        do_refill(3'd0, 8'd5);
        do_refill(3'd7, 8'd5);
        for (int c = 1; c <= 6; c++) begin
            inv_sel = 3'(c); #1;
            total++;
            if (inv_count !== ((c == 4) ? 8'd255 : 8'd8)) begin
                bad++; $display("FAIL refill_ignore code=%0d got=%0d exp=%0d", c, inv_count, (c == 4) ? 255 : 8);
            end
        end
        apply_reset();
        inv_sel = 3'd4;
        do_refill(3'd4, 8'd2);
        total++; if (inv_count !== 8'd10) begin bad++; $display("FAIL refill_to10 got=%0d exp=10", inv_count); end
        @(negedge clk);
        bus.coin_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_amount = 11'd10;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.coin_valid !== 1'b1 || bus.coin_code !== 3'd4) begin bad++; $display("FAIL refill_emit got=v%b c%0d exp=v1 c4", bus.coin_valid, bus.coin_code); end
        bus.coin_ready = 1'b1;
        refill_valid   = 1'b1;
        refill_code    = 3'd4;
        refill_qty     = 8'd3;
        @(negedge clk);
        refill_valid = 1'b0;
        #1;
        total++; if (inv_count !== 8'd12) begin bad++; $display("FAIL refill_with_dec got=%0d exp=12", inv_count); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL refill_done got=%b exp=1", bus.done); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        apply_reset();
        do_refill(3'd6, 8'd5);
        @(negedge clk);
        bus.coin_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_amount = 11'd50;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.coin_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.coin_valid); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.coin_valid !== 1'b0 || bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_outputs got=v%b d%b r%b exp=v0 d0 r1", bus.coin_valid, bus.done, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.coin_ready = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", done_seen); end
        for (int c = 1; c <= 6; c++) begin
            inv_sel = 3'(c); #1;
            total++; if (inv_count !== 8'd8) begin bad++; $display("FAIL midrst_inv code=%0d got=%0d exp=8", c, inv_count); end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        bus.coin_ready = 1'b1;
        test_reset();
        test_greedy_87();
        test_depleted_50();
        test_stall();
        test_shortfall();
        test_refill();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
